// File: rtl/bcd_reverse_transfer_pkg.sv
// Shared definitions for the BCD-to-binary reverse-transfer converter.
// Holds the controller state type, the datapath sizing constants and the
// digit-legality helper used when an operand is accepted.
package bcd_reverse_transfer_pkg;

   // Controller states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_SIGN  = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Width of the binary magnitude (0..99 fits in 7 bits)
   localparam int unsigned BIN_W = 7;

   // Number of shift/adjust iterations needed to drain two BCD digits
   localparam int unsigned ITER_COUNT = 7;

   // Digit correction after each right shift: values >= 8 lose 3
   localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;
   localparam logic [3:0] BCD_ADJ_SUB    = 4'd3;

   // Largest legal BCD digit
   localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

   // True when a 4-bit code is a legal decimal digit
   function automatic logic is_bcd_digit(input logic [3:0] digit);
      return (digit <= BCD_DIGIT_MAX);
   endfunction

endpackage : bcd_reverse_transfer_pkg

// File: rtl/bcd_reverse_transfer_if.sv
// Handshake bundle for bcd_reverse_transfer.
//   Input side : in_valid/in_ready with operand in_sign, in_tens, in_ones.
//   Output side: out_valid/out_ready with result (8-bit two's complement)
//                and err (illegal BCD digit seen).
// The slave modport is the converter; the master modport is its
// environment (operand source and result sink together).
interface bcd_reverse_transfer_if;

   logic       in_valid;
   logic       in_ready;
   logic       in_sign;
   logic [3:0] in_tens;
   logic [3:0] in_ones;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] result;
   logic       err;

   modport slave (
      input  in_valid,
      input  in_sign,
      input  in_tens,
      input  in_ones,
      input  out_ready,
      output in_ready,
      output out_valid,
      output result,
      output err
   );

   modport master (
      output in_valid,
      output in_sign,
      output in_tens,
      output in_ones,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  result,
      input  err
   );

endinterface : bcd_reverse_transfer_if

// File: rtl/bcd_reverse_transfer_digit_adjust.sv
// bcd_digit_adjust: single-digit correction step of the reverse
// double-dabble conversion. After a right shift, a digit that received
// the carried-in bit from the digit above reads 8 too high in its MSB
// position where it should be worth 5; subtracting 3 restores it.
//   digit_in  : 4-bit shifted digit
//   digit_out : corrected digit
module bcd_digit_adjust
   import bcd_reverse_transfer_pkg::*;
(
   input  logic [3:0] digit_in,
   output logic [3:0] digit_out
);

   // Conditional subtract of the correction constant
   always_comb begin
      digit_out = digit_in;
      if (digit_in >= BCD_ADJ_THRESH) begin
         digit_out = digit_in - BCD_ADJ_SUB;
      end else begin
         digit_out = digit_in;
      end
   end

endmodule : bcd_digit_adjust

// File: rtl/bcd_reverse_transfer.sv
// bcd_reverse_transfer: converts a signed two-digit BCD operand into an
// 8-bit two's-complement value using the shift-right / subtract-3
// (reverse double-dabble) algorithm.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : operand input handshake and result output handshake
// A legal operand takes 7 shift cycles plus one sign cycle, so the result
// appears 8 cycles after acceptance; an illegal operand goes straight to
// DONE with err set. One operation at a time: in_ready is high only in IDLE.
module bcd_reverse_transfer
   import bcd_reverse_transfer_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   bcd_reverse_transfer_if.slave bus
);

   localparam int unsigned SREG_W    = 8 + BIN_W;
   localparam logic [2:0]  LAST_ITER = 3'(ITER_COUNT - 1);

   state_e            state_q,     state_d;
   logic [2:0]        cnt_q,       cnt_d;
   logic [SREG_W-1:0] sreg_q,      sreg_d;
   logic              sign_q,      sign_d;
   logic [7:0]        result_q,    result_d;
   logic              err_q,       err_d;
   logic              out_valid_q, out_valid_d;
   logic              in_ready_q,  in_ready_d;

   logic              accept_s;
   logic [SREG_W-1:0] shifted_s;
   logic [3:0]        tens_adj_s;
   logic [3:0]        ones_adj_s;
   logic [SREG_W-1:0] iter_s;
   logic [7:0]        mag_s;

   assign accept_s  = bus.in_valid & in_ready_q;

   // One iteration: shift {tens,ones,bin} right, then correct each digit
   assign shifted_s = {1'b0, sreg_q[SREG_W-1:1]};

   bcd_digit_adjust u_adj_tens (
      .digit_in  (shifted_s[SREG_W-1 -: 4]),
      .digit_out (tens_adj_s)
   );

   bcd_digit_adjust u_adj_ones (
      .digit_in  (shifted_s[BIN_W+3 -: 4]),
      .digit_out (ones_adj_s)
   );

   assign iter_s = {tens_adj_s, ones_adj_s, shifted_s[BIN_W-1:0]};
   assign mag_s  = {1'b0, sreg_q[BIN_W-1:0]};

   // Next-state and datapath load logic
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sreg_d   = sreg_q;
      sign_d   = sign_q;
      result_d = result_q;
      err_d    = err_q;

      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               sign_d = bus.in_sign;
               if (is_bcd_digit(bus.in_tens) && is_bcd_digit(bus.in_ones)) begin
                  state_d = ST_SHIFT;
                  cnt_d   = 3'd0;
                  sreg_d  = {bus.in_tens, bus.in_ones, {BIN_W{1'b0}}};
               end else begin
                  // Illegal digit: report immediately, no conversion
                  state_d  = ST_DONE;
                  result_d = 8'h00;
                  err_d    = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_SHIFT: begin
            sreg_d = iter_s;
            if (cnt_q == LAST_ITER) begin
               cnt_d   = 3'd0;
               state_d = ST_SIGN;
            end else begin
               cnt_d   = cnt_q + 3'd1;
            end
         end

         ST_SIGN: begin
            // Negating zero yields zero, so -0 needs no special case
            if (sign_q) begin
               result_d = 8'd0 - mag_s;
            end else begin
               result_d = mag_s;
            end
            err_d   = 1'b0;
            state_d = ST_DONE;
         end

         ST_DONE: begin
            if (bus.out_ready) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
         end
      endcase

      // Handshake flags registered alongside the state they reflect
      in_ready_d  = (state_d == ST_IDLE);
      out_valid_d = (state_d == ST_DONE);
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 3'd0;
         sreg_q      <= {SREG_W{1'b0}};
         sign_q      <= 1'b0;
         result_q    <= 8'h00;
         err_q       <= 1'b0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sreg_q      <= sreg_d;
         sign_q      <= sign_d;
         result_q    <= result_d;
         err_q       <= err_d;
         out_valid_q <= out_valid_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.err       = err_q;

endmodule : bcd_reverse_transfer

// File: tb/tb_bcd_reverse_transfer.sv
// Testbench for bcd_reverse_transfer: table of directed operands with
// hand-computed results, plus sequences for result stall, ignored input
// while busy, and reset in the middle of a conversion.
module tb_bcd_reverse_transfer;

   logic clk;
   logic rst_n;

   bcd_reverse_transfer_if bus ();

   bcd_reverse_transfer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       sign;
      logic [3:0] tens;
      logic [3:0] ones;
      logic [7:0] exp_res;
      logic       exp_err;
   } vec_t;

   localparam int NVEC = 14;
   vec_t vecs [NVEC];

   int n_checks = 0;
   int n_bad    = 0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Caller is at a falling edge with out_ready=1; returns at a falling edge
   task automatic run_vec(input vec_t v, input string tag);
      int lat;
      check({tag, "_in_ready_idle"}, int'(bus.in_ready), 1);
      bus.in_valid = 1'b1;
      bus.in_sign  = v.sign;
      bus.in_tens  = v.tens;
      bus.in_ones  = v.ones;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, "_latency"}, lat, v.exp_err ? 0 : 8);
      check({tag, "_result"}, int'(bus.result), int'(v.exp_res));
      check({tag, "_err"}, int'(bus.err), int'(v.exp_err));
      check({tag, "_in_ready_busy"}, int'(bus.in_ready), 0);
      @(posedge clk);
      #1;
      check({tag, "_retired"}, int'(bus.out_valid), 0);
      @(negedge clk);
   endtask

   initial begin
      int lat;
      int seen;

      vecs[0]  = '{1'b0, 4'd4, 4'd5, 8'h2D, 1'b0};   // +45
      vecs[1]  = '{1'b1, 4'd9, 4'd9, 8'h9D, 1'b0};   // -99
      vecs[2]  = '{1'b0, 4'd9, 4'd9, 8'h63, 1'b0};   // +99
      vecs[3]  = '{1'b1, 4'd0, 4'd0, 8'h00, 1'b0};   // -0
      vecs[4]  = '{1'b0, 4'hA, 4'd3, 8'h00, 1'b1};   // illegal tens
      vecs[5]  = '{1'b0, 4'd0, 4'd0, 8'h00, 1'b0};   // +0
      vecs[6]  = '{1'b1, 4'd0, 4'd1, 8'hFF, 1'b0};   // -1
      vecs[7]  = '{1'b0, 4'd5, 4'd0, 8'h32, 1'b0};   // +50
      vecs[8]  = '{1'b1, 4'd5, 4'd0, 8'hCE, 1'b0};   // -50
      vecs[9]  = '{1'b1, 4'd3, 4'hF, 8'h00, 1'b1};   // illegal ones
      vecs[10] = '{1'b0, 4'd0, 4'd9, 8'h09, 1'b0};   // +9
      vecs[11] = '{1'b1, 4'd1, 4'd0, 8'hF6, 1'b0};   // -10
      vecs[12] = '{1'b0, 4'd8, 4'd0, 8'h50, 1'b0};   // +80
      vecs[13] = '{1'b0, 4'd6, 4'd7, 8'h43, 1'b0};   // +67

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_sign   = 1'b0;
      bus.in_tens   = 4'd0;
      bus.in_ones   = 4'd0;
      bus.out_ready = 1'b1;

      repeat (3) @(negedge clk);
      check("rst_in_ready", int'(bus.in_ready), 1);
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_result", int'(bus.result), 0);
      check("rst_err", int'(bus.err), 0);

      // First operand is presented on the same edge reset is released
      rst_n = 1'b1;
      for (int i = 0; i < NVEC; i++) begin
         run_vec(vecs[i], $sformatf("v%0d", i));
      end

      // -7 with the sink stalled for 5 cycles; a new operand is offered meanwhile
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_sign   = 1'b1;
      bus.in_tens   = 4'd0;
      bus.in_ones   = 4'd7;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("stall_latency", lat, 8);
      check("stall_result", int'(bus.result), 8'hF9);
      bus.in_valid = 1'b1;
      bus.in_sign  = 1'b0;
      bus.in_tens  = 4'd1;
      bus.in_ones  = 4'd1;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("stall%0d_result", k), int'(bus.result), 8'hF9);
         check($sformatf("stall%0d_valid", k), int'(bus.out_valid), 1);
         check($sformatf("stall%0d_in_ready", k), int'(bus.in_ready), 0);
      end
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("stall_release_valid", int'(bus.out_valid), 0);
      check("stall_release_in_ready", int'(bus.in_ready), 1);
      check("stall_hold_result", int'(bus.result), 8'hF9);
      check("stall_hold_err", int'(bus.err), 0);

      // Reset pulse during the third shift iteration
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_sign  = 1'b0;
      bus.in_tens  = 4'd4;
      bus.in_ones  = 4'd5;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", int'(bus.out_valid), 0);
      check("midrst_in_ready", int'(bus.in_ready), 1);
      check("midrst_result", int'(bus.result), 0);
      rst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk);
         #1;
         if (bus.out_valid) seen = 1;
      end
      check("midrst_no_output", seen, 0);
      @(negedge clk);
      run_vec('{1'b0, 4'd1, 4'd2, 8'h0C, 1'b0}, "after_rst_p12");

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_bad);
      $finish;
   end

endmodule : tb_bcd_reverse_transfer
